// File: rtl/axi_boxcar_hold_pkg.sv
// Shared types and helpers for the boxcar-average / zero-order-hold stage.
//   sc16_t        : packed complex sample, I in [31:16], Q in [15:0]
//   out_state_e   : output-side holding register state
//   acc_w()       : accumulator width needed for a MAX_N-word sum
//   shift_for_n() : ceil(log2(n)), the normalising shift for an n-word sum
//   clamp_factor(): maps a raw rate factor into 1..max
package axi_boxcar_hold_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SHIFT_W  = 5;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] i;
    logic signed [SAMPLE_W-1:0] q;
  } sc16_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_e;

  function automatic int acc_w(input int max_n);
    return SAMPLE_W + $clog2(max_n);
  endfunction

  // Bounded loop so it stays synthesizable; covers any n up to 2^16.
  function automatic logic [SHIFT_W-1:0] shift_for_n(input int n);
    logic [SHIFT_W-1:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) begin
      if ((1 << k) < n) s = SHIFT_W'(k + 1);
    end
    return s;
  endfunction

  // A factor of 0 means 1; anything above the built-in maximum saturates.
  function automatic int clamp_factor(input int v, input int max_v);
    if (v == 0) return 1;
    if (v > max_v) return max_v;
    return v;
  endfunction

endpackage

// File: rtl/axi_boxcar_hold_acc.sv
// One rail (I or Q) of the boxcar averager.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous flush of the running sum
//   acc_en       : a word is accepted this cycle
//   acc_zero     : the accepted word ends the group (complete or discarded)
//   shift        : normalising shift ceil(log2 N) for the current group
//   din          : signed input sample
//   avg          : rounded average of the running sum plus din; only
//                  meaningful on the cycle the group completes
module axi_boxcar_hold_acc
  import axi_boxcar_hold_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       acc_en,
  input  logic                       acc_zero,
  input  logic [SHIFT_W-1:0]         shift,
  input  logic signed [SAMPLE_W-1:0] din,
  output logic signed [SAMPLE_W-1:0] avg
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] rounded;

  // The completing word is folded in combinationally so the average is
  // ready on the same clock as the Nth accept.
  assign sum = acc_q + {{(ACC_W-SAMPLE_W){din[SAMPLE_W-1]}}, din};

  // Round half up: add 2^(s-1) before the arithmetic shift. ACC_W leaves
  // room for this even with MAX_N full-scale words, and a sum of N words
  // shifted by ceil(log2 N) always fits back into 16 bits.
  always_comb begin
    rnd = '0;
    if (shift != '0) rnd[shift - 1'b1] = 1'b1;
  end

  assign rounded = sum + rnd;
  assign avg     = SAMPLE_W'(rounded >>> shift);

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_zero ? '0 : sum;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/axi_boxcar_hold.sv
// Rate-change stage: averages each group of N sc16 words (boxcar) and
// presents the result M times (zero-order hold), giving a net rate of M/N.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   clear             : synchronous flush of groups and held output
//   n, m              : decimation and hold factors, latched per group
//   i_tdata/tlast/tvalid/tready : input AXI-Stream (sc16, I=[31:16])
//   o_tdata/tlast/tvalid/tready : output AXI-Stream
//   dropped_partial   : one-cycle pulse when i_tlast cuts a group short
module axi_boxcar_hold
  import axi_boxcar_hold_pkg::*;
#(
  parameter  int MAX_N = 16,
  parameter  int MAX_M = 16,
  localparam int N_W   = $clog2(MAX_N + 1),
  localparam int M_W   = $clog2(MAX_M + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear,
  input  logic [N_W-1:0] n,
  input  logic [M_W-1:0] m,
  input  logic [31:0]    i_tdata,
  input  logic           i_tlast,
  input  logic           i_tvalid,
  output logic           i_tready,
  output logic [31:0]    o_tdata,
  output logic           o_tlast,
  output logic           o_tvalid,
  input  logic           o_tready,
  output logic           dropped_partial
);

  localparam int ACC_W = acc_w(MAX_N);

  sc16_t din;
  assign din = i_tdata;

  // Input-side group tracking
  logic             rdy_en_q, rdy_en_d;
  logic [N_W-1:0]   in_cnt_q, in_cnt_d;
  logic [N_W-1:0]   n_lat_q, n_lat_d;
  logic [M_W-1:0]   m_lat_q, m_lat_d;
  logic             drop_q, drop_d;

  logic [N_W-1:0]   n_eff, n_cur, in_cnt_inc;
  logic [M_W-1:0]   m_eff, m_cur;
  logic             group_start;
  logic             last_of_group;
  logic             out_free;
  logic             accept;
  logic             complete;
  logic             partial;
  logic             acc_zero;
  logic [SHIFT_W-1:0] shift;

  // Output-side holding register
  out_state_e       state_q, state_d;
  sc16_t            out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [M_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [M_W-1:0]   m_out_q, m_out_d;
  logic             final_rep;

  logic signed [SAMPLE_W-1:0] res_i, res_q;
  sc16_t            res;

  assign n_eff = N_W'(clamp_factor(int'(n), MAX_N));
  assign m_eff = M_W'(clamp_factor(int'(m), MAX_M));

  // An empty count means the next accepted word opens a group, so the live
  // factor inputs apply to it; afterwards the latched copies are used.
  assign group_start   = (in_cnt_q == '0);
  assign n_cur         = group_start ? n_eff : n_lat_q;
  assign m_cur         = group_start ? m_eff : m_lat_q;
  assign in_cnt_inc    = in_cnt_q + N_W'(1);
  assign last_of_group = (in_cnt_inc == n_cur);

  // m_out_q is the hold factor of the group now on the output, which can
  // differ from the one being accumulated.
  assign final_rep = (rep_cnt_q == m_out_q);
  assign out_free  = (state_q == OUT_EMPTY) | (o_tready & final_rep);

  // Only the word that would produce a result needs room at the output;
  // every other word of a group is taken unconditionally.
  assign i_tready = rdy_en_q & (~last_of_group | out_free);

  assign accept   = i_tvalid & i_tready & ~clear;
  assign complete = accept & last_of_group;
  assign partial  = accept & ~last_of_group & i_tlast;
  assign acc_zero = complete | partial;
  assign shift    = shift_for_n(int'(n_cur));

  axi_boxcar_hold_acc #(.ACC_W(ACC_W)) u_acc_i (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .acc_en   (accept),
    .acc_zero (acc_zero),
    .shift    (shift),
    .din      (din.i),
    .avg      (res_i)
  );

  axi_boxcar_hold_acc #(.ACC_W(ACC_W)) u_acc_q (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .acc_en   (accept),
    .acc_zero (acc_zero),
    .shift    (shift),
    .din      (din.q),
    .avg      (res_q)
  );

  always_comb begin
    res   = '0;
    res.i = res_i;
    res.q = res_q;
  end

  // Group control. An early i_tlast ends the group, so group tlast is only
  // ever carried by the Nth word; it is captured with the result below.
  always_comb begin
    rdy_en_d = 1'b1;
    in_cnt_d = in_cnt_q;
    n_lat_d  = n_lat_q;
    m_lat_d  = m_lat_q;
    drop_d   = 1'b0;
    if (clear) begin
      in_cnt_d = '0;
      n_lat_d  = '0;
      m_lat_d  = '0;
    end else if (accept) begin
      if (group_start) begin
        n_lat_d = n_eff;
        m_lat_d = m_eff;
      end
      in_cnt_d = acc_zero ? '0 : in_cnt_inc;
      drop_d   = partial;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en_q <= 1'b0;
      in_cnt_q <= '0;
      n_lat_q  <= '0;
      m_lat_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      rdy_en_q <= rdy_en_d;
      in_cnt_q <= in_cnt_d;
      n_lat_q  <= n_lat_d;
      m_lat_q  <= m_lat_d;
      drop_q   <= drop_d;
    end
  end

  // Output FSM. A new result may only arrive while empty or in the same
  // clock the final repetition is taken, which the ready term guarantees.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    rep_cnt_d  = rep_cnt_q;
    m_out_d    = m_out_q;
    if (clear) begin
      state_d    = OUT_EMPTY;
      out_data_d = '0;
      out_last_d = 1'b0;
      rep_cnt_d  = '0;
      m_out_d    = '0;
    end else begin
      unique case (state_q)
        OUT_EMPTY: begin
          if (complete) begin
            state_d    = OUT_HOLD;
            out_data_d = res;
            out_last_d = i_tlast;
            rep_cnt_d  = M_W'(1);
            m_out_d    = m_cur;
          end
        end
        OUT_HOLD: begin
          if (complete) begin
            state_d    = OUT_HOLD;
            out_data_d = res;
            out_last_d = i_tlast;
            rep_cnt_d  = M_W'(1);
            m_out_d    = m_cur;
          end else if (o_tready) begin
            if (final_rep) begin
              state_d    = OUT_EMPTY;
              out_last_d = 1'b0;
              rep_cnt_d  = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + M_W'(1);
            end
          end
        end
        default: state_d = OUT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OUT_EMPTY;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      rep_cnt_q  <= '0;
      m_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      rep_cnt_q  <= rep_cnt_d;
      m_out_q    <= m_out_d;
    end
  end

  assign o_tvalid        = (state_q == OUT_HOLD);
  assign o_tdata         = out_data_q;
  // tlast marks only the final repetition of a tlast-carrying group.
  assign o_tlast         = o_tvalid & out_last_q & final_rep;
  assign dropped_partial = drop_q;

endmodule
